adpll_dco: RTL and testbench

//  Counter-based digitally controlled oscillator (DCO): the actuation end of the ADPLL loop.

---
 rtl/adpll_pkg.sv | 28 ++
 rtl/adpll_dco_if.sv | 9 +
 rtl/adpll_dco_period_calc.sv | 38 +++
 rtl/adpll_dco.sv | 108 ++++++++++
 tb/tb_adpll_dco.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/adpll_pkg.sv
// Shared types and helpers for the counter-based DCO at the actuation end of the ADPLL loop.
package adpll_pkg;
  localparam int CTRL_W   = 5;
  localparam int PERIOD_W = 16;
  localparam int SAT_W    = 64;

  typedef logic signed [CTRL_W-1:0] ctrl_t;
  typedef logic [PERIOD_W-1:0]      period_t;

  typedef enum logic {ST_LOW, ST_HIGH} dco_state_t;

  typedef struct packed {
    period_t period;
    logic    clamp;
  } sat_res_t;

  // Reference form of the period update at the default widths.
  function automatic sat_res_t sat_period(period_t base, ctrl_t ctrl, int unsigned shift,
                                          period_t pmin, period_t pmax);
    logic signed [SAT_W-1:0] d;
    sat_res_t r;
    d = signed'(SAT_W'(base)) - (SAT_W'(ctrl) <<< shift);
    if (d < signed'(SAT_W'(pmin)))      r = '{pmin, 1'b1};
    else if (d > signed'(SAT_W'(pmax))) r = '{pmax, 1'b1};
    else                                r = '{d[PERIOD_W-1:0], 1'b0};
    return r;
  endfunction
endpackage

// File: rtl/adpll_dco_if.sv
// Control-word handshake between the loop filter / phase detector and the DCO.
interface adpll_dco_if #(parameter int WIDTH = adpll_pkg::CTRL_W);
  logic signed [WIDTH-1:0] ctrl_i;
  logic                    ctrl_valid_i;
  logic                    ctrl_ready_o;

  modport master (output ctrl_i, output ctrl_valid_i, input ctrl_ready_o);
  modport slave  (input ctrl_i, input ctrl_valid_i, output ctrl_ready_o);
endinterface

// File: rtl/adpll_dco_period_calc.sv
// Combinational next-period computation: base minus scaled control word, saturated.
module dco_period_calc #(
  parameter int WIDTH         = 5,
  parameter int PERIOD_WIDTH  = 16,
  parameter int CENTER_PERIOD = 1000,
  parameter int MIN_PERIOD    = 4,
  parameter int MAX_PERIOD    = 65535,
  parameter int GAIN_SHIFT    = 0,
  parameter int ACCUMULATE    = 0
) (
  input  logic signed [WIDTH-1:0]  i_ctrl,
  input  logic [PERIOD_WIDTH-1:0]  i_period_cur,
  output logic [PERIOD_WIDTH-1:0]  o_period,
  output logic                     o_clamp
);
  // Wide enough that neither the shifted word nor the difference can wrap.
  localparam int EW = PERIOD_WIDTH + WIDTH + GAIN_SHIFT + 1;
  localparam logic signed [EW-1:0] MIN_S = EW'(MIN_PERIOD);
  localparam logic signed [EW-1:0] MAX_S = EW'(MAX_PERIOD);
  localparam logic [PERIOD_WIDTH-1:0] CENTER_P = PERIOD_WIDTH'(CENTER_PERIOD);

  logic signed [EW-1:0] w_base, w_adj, w_diff;

  always_comb begin
    w_base = signed'(EW'((ACCUMULATE != 0) ? i_period_cur : CENTER_P));
    w_adj  = EW'(i_ctrl) <<< GAIN_SHIFT;
    w_diff = w_base - w_adj;
    o_period = w_diff[PERIOD_WIDTH-1:0];
    o_clamp  = 1'b0;
    if (w_diff < MIN_S) begin
      o_period = PERIOD_WIDTH'(MIN_PERIOD);
      o_clamp  = 1'b1;
    end else if (w_diff > MAX_S) begin
      o_period = PERIOD_WIDTH'(MAX_PERIOD);
      o_clamp  = 1'b1;
    end
  end
endmodule

// File: rtl/adpll_dco.sv
// Counter-based DCO: glitch-free clock synthesis with period updates only at rising-edge boundaries.
module adpll_dco
  import adpll_pkg::*;
#(
  parameter int WIDTH         = CTRL_W,
  parameter int PERIOD_WIDTH  = PERIOD_W,
  parameter int CENTER_PERIOD = 1000,
  parameter int MIN_PERIOD    = 4,
  parameter int MAX_PERIOD    = 65535,
  parameter int GAIN_SHIFT    = 0,
  parameter int ACCUMULATE    = 0
) (
  input  logic                    fpga_clk_i,
  input  logic                    reset_i,
  adpll_dco_if.slave              bus,
  output logic                    generated_o,
  output logic                    edge_o,
  output logic [PERIOD_WIDTH-1:0] period_o,
  output logic                    clamp_o
);
  localparam logic [PERIOD_WIDTH-1:0] ONE = PERIOD_WIDTH'(1);

  dco_state_t               r_state;
  logic [PERIOD_WIDTH-1:0]  r_cnt;
  logic [PERIOD_WIDTH-1:0]  r_period;
  logic                     r_gen;
  logic                     r_edge;
  logic                     r_clamp;
  logic                     r_pend_full;
  logic signed [WIDTH-1:0]  r_pend_ctrl;

  logic [PERIOD_WIDTH-1:0]  w_calc_p;
  logic                     w_calc_clamp;
  logic [PERIOD_WIDTH-1:0]  w_next_p;
  logic [PERIOD_WIDTH-1:0]  w_high_m1;
  logic [PERIOD_WIDTH-1:0]  w_low_m1;
  logic                     w_cap;

  dco_period_calc #(
    .WIDTH(WIDTH), .PERIOD_WIDTH(PERIOD_WIDTH), .CENTER_PERIOD(CENTER_PERIOD),
    .MIN_PERIOD(MIN_PERIOD), .MAX_PERIOD(MAX_PERIOD), .GAIN_SHIFT(GAIN_SHIFT),
    .ACCUMULATE(ACCUMULATE)
  ) u_calc (
    .i_ctrl       (r_pend_ctrl),
    .i_period_cur (r_period),
    .o_period     (w_calc_p),
    .o_clamp      (w_calc_clamp)
  );

  // Period that starts at the coming boundary; low phase takes the odd cycle.
  assign w_next_p  = r_pend_full ? w_calc_p : r_period;
  assign w_high_m1 = (w_next_p >> 1) - ONE;
  assign w_low_m1  = r_period - (r_period >> 1) - ONE;

  assign w_cap            = bus.ctrl_valid_i & ~r_pend_full;
  assign bus.ctrl_ready_o = ~r_pend_full;

  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state     <= ST_LOW;
      r_cnt       <= '0;
      r_period    <= PERIOD_WIDTH'(CENTER_PERIOD);
      r_gen       <= 1'b0;
      r_edge      <= 1'b0;
      r_clamp     <= 1'b0;
      r_pend_full <= 1'b0;
      r_pend_ctrl <= '0;
    end else begin
      r_edge <= 1'b0;
      if (w_cap) begin
        r_pend_full <= 1'b1;
        r_pend_ctrl <= bus.ctrl_i;
      end
      case (r_state)
        ST_HIGH: begin
          if (r_cnt == '0) begin
            r_state <= ST_LOW;
            r_gen   <= 1'b0;
            r_cnt   <= w_low_m1;
          end else begin
            r_cnt <= r_cnt - ONE;
          end
        end
        default: begin
          if (r_cnt == '0) begin
            // Boundary; a word captured this same cycle waits for the next one.
            r_state <= ST_HIGH;
            r_gen   <= 1'b1;
            r_edge  <= 1'b1;
            r_cnt   <= w_high_m1;
            if (r_pend_full) begin
              r_period    <= w_calc_p;
              r_clamp     <= w_calc_clamp;
              r_pend_full <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt - ONE;
          end
        end
      endcase
    end
  end

  assign generated_o = r_gen;
  assign edge_o      = r_edge;
  assign period_o    = r_period;
  assign clamp_o     = r_clamp;
endmodule

// File: tb/tb_adpll_dco.sv
// Directed bench for adpll_dco: absolute (inst 0) and accumulating (inst 1) DCOs, CENTER=10.
module tb_adpll_dco;
  logic clk = 1'b0;
  logic reset_i = 1'b1;
  always #5 clk = ~clk;

  logic [1:0] gen, edg, rdy, clmp;
  logic [15:0] per [2];
  int checks = 0;
  int failures = 0;

  adpll_dco_if #(.WIDTH(5)) bus0 ();
  adpll_dco_if #(.WIDTH(5)) bus1 ();

  adpll_dco #(.WIDTH(5), .PERIOD_WIDTH(16), .CENTER_PERIOD(10), .MIN_PERIOD(4),
              .MAX_PERIOD(40), .GAIN_SHIFT(0), .ACCUMULATE(0)) dut0 (
    .fpga_clk_i(clk), .reset_i(reset_i), .bus(bus0),
    .generated_o(gen[0]), .edge_o(edg[0]), .period_o(per[0]), .clamp_o(clmp[0]));

  adpll_dco #(.WIDTH(5), .PERIOD_WIDTH(16), .CENTER_PERIOD(10), .MIN_PERIOD(4),
              .MAX_PERIOD(40), .GAIN_SHIFT(0), .ACCUMULATE(1)) dut1 (
    .fpga_clk_i(clk), .reset_i(reset_i), .bus(bus1),
    .generated_o(gen[1]), .edge_o(edg[1]), .period_o(per[1]), .clamp_o(clmp[1]));

  assign rdy[0] = bus0.ctrl_ready_o;
  assign rdy[1] = bus1.ctrl_ready_o;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input int idx, input int v);
    if (idx == 0) begin bus0.ctrl_i = 5'(v); bus0.ctrl_valid_i = 1'b1; end
    else          begin bus1.ctrl_i = 5'(v); bus1.ctrl_valid_i = 1'b1; end
    @(negedge clk);
    bus0.ctrl_valid_i = 1'b0;
    bus1.ctrl_valid_i = 1'b0;
  endtask

  // Steps to the next edge_o pulse; n = negedges taken.
  task automatic sync_edge(input int idx, input string tag, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (edg[idx] !== 1'b1 && n < 200);
    chk({tag, "_edge_found"}, 32'(edg[idx]), 1);
  endtask

  // Starts on an edge cycle, ends on the next one.
  task automatic measure(input int idx, input string tag, input int exp_hi, input int exp_lo);
    int hi, lo;
    hi = 0; lo = 0;
    while (gen[idx] === 1'b1 && hi < 200) begin hi++; @(negedge clk); end
    while (gen[idx] === 1'b0 && lo < 200) begin lo++; @(negedge clk); end
    chk({tag, "_high"}, hi, exp_hi);
    chk({tag, "_low"}, lo, exp_lo);
    chk({tag, "_edge_at_rise"}, 32'(edg[idx]), 1);
  endtask

  int n;

  initial begin
    bus0.ctrl_i = '0; bus0.ctrl_valid_i = 1'b0;
    bus1.ctrl_i = '0; bus1.ctrl_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_gen", 32'(gen[0]), 0);
    chk("rst_edge", 32'(edg[0]), 0);
    chk("rst_period", 32'(per[0]), 10);
    chk("rst_clamp", 32'(clmp[0]), 0);
    chk("rst_ready", 32'(rdy[0]), 1);

    // 1: first rising edge one clock after release, then 5/5
    reset_i = 1'b0;
    @(negedge clk);
    chk("start_gen", 32'(gen[0]), 1);
    chk("start_edge", 32'(edg[0]), 1);
    measure(0, "free10", 5, 5);

    // 2: +2 mid high phase, current period unaffected
    repeat (2) @(negedge clk);
    send(0, 2);
    chk("p8_ready_low", 32'(rdy[0]), 0);
    chk("p8_period_hold", 32'(per[0]), 10);
    sync_edge(0, "p8", n);
    chk("p8_remaining", n, 7);
    chk("p8_period", 32'(per[0]), 8);
    chk("p8_ready_back", 32'(rdy[0]), 1);
    measure(0, "p8", 4, 4);

    // 3: odd period and negative word
    send(0, 1);
    sync_edge(0, "p9", n);
    chk("p9_remaining", n, 7);
    chk("p9_period", 32'(per[0]), 9);
    measure(0, "p9", 4, 5);
    send(0, -16);
    sync_edge(0, "p26", n);
    chk("p26_remaining", n, 8);
    chk("p26_period", 32'(per[0]), 26);
    chk("p26_clamp", 32'(clmp[0]), 0);
    measure(0, "p26", 13, 13);

    // 4: floor saturation, then recovery
    send(0, 15);
    sync_edge(0, "p4", n);
    chk("p4_remaining", n, 25);
    chk("p4_period", 32'(per[0]), 4);
    chk("p4_clamp", 32'(clmp[0]), 1);
    measure(0, "p4", 2, 2);
    send(0, 0);
    sync_edge(0, "p10", n);
    chk("p10_period", 32'(per[0]), 10);
    chk("p10_clamp", 32'(clmp[0]), 0);
    measure(0, "p10", 5, 5);

    // 5: accumulating instance; valid held 3 cycles gives a single capture
    sync_edge(1, "acc_sync", n);
    bus1.ctrl_i = 5'sd1; bus1.ctrl_valid_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("acc_hold_ready", 32'(rdy[1]), 0);
    bus1.ctrl_valid_i = 1'b0;
    sync_edge(1, "acc9", n);
    chk("acc9_remaining", n, 7);
    chk("acc9_period", 32'(per[1]), 9);
    chk("acc9_ready", 32'(rdy[1]), 1);
    sync_edge(1, "acc9b", n);
    chk("acc9b_len", n, 9);
    chk("acc9b_period", 32'(per[1]), 9);
    send(1, 1);
    sync_edge(1, "acc8", n);
    chk("acc8_remaining", n, 8);
    chk("acc8_period", 32'(per[1]), 8);
    send(1, -16);
    sync_edge(1, "acc24", n);
    chk("acc24_period", 32'(per[1]), 24);
    chk("acc24_clamp", 32'(clmp[1]), 0);
    send(1, -16);
    sync_edge(1, "acc40", n);
    chk("acc40_remaining", n, 23);
    chk("acc40_period", 32'(per[1]), 40);
    chk("acc40_clamp", 32'(clmp[1]), 0);
    measure(1, "acc40", 20, 20);
    send(1, -16);
    sync_edge(1, "accmax", n);
    chk("accmax_period", 32'(per[1]), 40);
    chk("accmax_clamp", 32'(clmp[1]), 1);
    send(1, 15);
    sync_edge(1, "acc25", n);
    chk("acc25_remaining", n, 39);
    chk("acc25_period", 32'(per[1]), 25);
    chk("acc25_clamp", 32'(clmp[1]), 0);

    // 6: capture on the boundary cycle is deferred by one period
    sync_edge(0, "bnd_sync", n);
    repeat (9) @(negedge clk);
    chk("bnd_pre_low", 32'(gen[0]), 0);
    send(0, 15);
    chk("bnd_edge", 32'(edg[0]), 1);
    chk("bnd_period_hold", 32'(per[0]), 10);
    chk("bnd_ready", 32'(rdy[0]), 0);
    sync_edge(0, "bnd_apply", n);
    chk("bnd_apply_len", n, 10);
    chk("bnd_apply_period", 32'(per[0]), 4);
    chk("bnd_apply_clamp", 32'(clmp[0]), 1);

    // reset mid-LOW with a word pending
    repeat (2) @(negedge clk);
    chk("mrst_low", 32'(gen[0]), 0);
    send(0, 3);
    chk("mrst_pending", 32'(rdy[0]), 0);
    reset_i = 1'b1;
    #1;
    chk("mrst_gen", 32'(gen[0]), 0);
    chk("mrst_edge", 32'(edg[0]), 0);
    chk("mrst_period", 32'(per[0]), 10);
    chk("mrst_clamp", 32'(clmp[0]), 0);
    chk("mrst_ready", 32'(rdy[0]), 1);
    @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    chk("mrst_start_edge", 32'(edg[0]), 1);
    chk("mrst_start_period", 32'(per[0]), 10);
    measure(0, "mrst_p10", 5, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
